// File: rtl/ww_pkg.sv
// Shared definitions for the washer water path: sequencer states, fault codes and
// the default timing values also used by the program FSM.
package ww_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_FILL_PAUSE,
    S_DRAIN,
    S_SETTLE,
    S_DONE,
    S_FAULT
  } ww_state_t;

  localparam logic [1:0] FC_NONE          = 2'b00;
  localparam logic [1:0] FC_FILL_TIMEOUT  = 2'b01;
  localparam logic [1:0] FC_DRAIN_TIMEOUT = 2'b10;
  localparam logic [1:0] FC_DOOR_DRAIN    = 2'b11;

  localparam logic [7:0] DEF_FILL_TIMEOUT  = 8'd60;
  localparam logic [7:0] DEF_DRAIN_TIMEOUT = 8'd40;
  localparam logic [2:0] DEF_DEBOUNCE      = 3'd3;
  localparam logic [2:0] DEF_SETTLE        = 3'd4;

endpackage

// File: rtl/level_debounce.sv
// Level sensor debouncer: the input counts as asserted once it has been high for
// DEBOUNCE consecutive cycles; any low cycle restarts the count.
module level_debounce
  import ww_pkg::*;
#(
  parameter logic [2:0] DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  logic [2:0] count;

  always_ff @(posedge clk) begin
    if (rst || !raw) begin
      count <= 3'd0;
    end else if (count != 3'd7) begin
      count <= count + 3'd1;
    end
  end

  assign stable = (count >= DEBOUNCE);

endmodule

// File: rtl/water_level_controller.sv
// Fill/drain sequencer: drives the inlet/outlet valves until the debounced level
// sensor confirms, with timeouts, door interlock, done pulse and latched fault.
module water_level_controller
  import ww_pkg::*;
#(
  parameter logic [7:0] FILL_TIMEOUT  = DEF_FILL_TIMEOUT,
  parameter logic [7:0] DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
  parameter logic [2:0] DEBOUNCE      = DEF_DEBOUNCE,
  parameter logic [2:0] SETTLE        = DEF_SETTLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fill_req,
  input  logic       drain_req,
  input  logic       hot_sel,
  input  logic       abort,
  input  logic       doorclosed,
  input  logic       level_full,
  input  logic       level_empty,
  output logic       valve_in_cold,
  output logic       valve_in_hot,
  output logic       valve_out,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code
);

  ww_state_t  state, state_nxt;
  logic [7:0] cnt, cnt_nxt, cnt_inc;
  logic [1:0] code_nxt;
  logic       hot, hot_nxt;
  logic       full_db, empty_db;

  level_debounce #(.DEBOUNCE(DEBOUNCE)) u_full_db (
    .clk(clk), .rst(rst), .raw(level_full), .stable(full_db)
  );

  level_debounce #(.DEBOUNCE(DEBOUNCE)) u_empty_db (
    .clk(clk), .rst(rst), .raw(level_empty), .stable(empty_db)
  );

  // cnt_inc includes the current cycle, so a timeout of N gives exactly N valve-open cycles.
  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    code_nxt  = fault_code;
    hot_nxt   = hot;
    if (abort) begin
      state_nxt = S_IDLE;
      cnt_nxt   = 8'd0;
      code_nxt  = FC_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (drain_req) begin
            state_nxt = S_DRAIN;
            cnt_nxt   = 8'd0;
          end else if (fill_req && doorclosed) begin
            state_nxt = S_FILL;
            cnt_nxt   = 8'd0;
            hot_nxt   = hot_sel;
          end
        end
        // The cycle the door is seen open still had the inlet open, so it is counted;
        // >= keeps a timeout that lands on that cycle effective after the pause.
        S_FILL: begin
          if (full_db) begin
            state_nxt = S_SETTLE;
            cnt_nxt   = 8'd0;
          end else if (!doorclosed) begin
            state_nxt = S_FILL_PAUSE;
            cnt_nxt   = cnt_inc;
          end else if (cnt_inc >= FILL_TIMEOUT) begin
            state_nxt = S_FAULT;
            code_nxt  = FC_FILL_TIMEOUT;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        S_FILL_PAUSE: begin
          if (doorclosed) state_nxt = S_FILL;
        end
        S_DRAIN: begin
          if (empty_db) begin
            state_nxt = S_SETTLE;
            cnt_nxt   = 8'd0;
          end else if (!doorclosed) begin
            state_nxt = S_FAULT;
            code_nxt  = FC_DOOR_DRAIN;
          end else if (cnt_inc >= DRAIN_TIMEOUT) begin
            state_nxt = S_FAULT;
            code_nxt  = FC_DRAIN_TIMEOUT;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        S_SETTLE: begin
          if (cnt_inc >= {5'd0, SETTLE}) begin
            state_nxt = S_DONE;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        S_FAULT: state_nxt = S_FAULT;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= 8'd0;
      hot           <= 1'b0;
      fault_code    <= FC_NONE;
      valve_in_cold <= 1'b0;
      valve_in_hot  <= 1'b0;
      valve_out     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      hot           <= hot_nxt;
      fault_code    <= code_nxt;
      valve_in_cold <= (state_nxt == S_FILL) && !hot_nxt;
      valve_in_hot  <= (state_nxt == S_FILL) && hot_nxt;
      valve_out     <= (state_nxt == S_DRAIN);
      busy          <= (state_nxt != S_IDLE);
      done          <= (state_nxt == S_DONE);
      fault         <= (state_nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_water_level_controller.sv
// Directed self-checking bench for water_level_controller; outputs are packed as
// {cold, hot, out, busy, done, fault, code[1:0]} and compared after each clock edge.
module tb_water_level_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       fill_req, drain_req, hot_sel, abort, doorclosed, level_full, level_empty;
  logic       valve_in_cold, valve_in_hot, valve_out, busy, done, fault;
  logic [1:0] fault_code;
  logic [7:0] outs;

  int check_count = 0;
  int error_count = 0;

  // Packed expectations: idle, fill hot, fill cold, drain, busy-only, done, faults.
  localparam logic [7:0] O_IDLE  = 8'h00;
  localparam logic [7:0] O_HOT   = 8'h50;
  localparam logic [7:0] O_COLD  = 8'h90;
  localparam logic [7:0] O_DRAIN = 8'h30;
  localparam logic [7:0] O_BUSY  = 8'h10;
  localparam logic [7:0] O_DONE  = 8'h18;
  localparam logic [7:0] O_F01   = 8'h15;
  localparam logic [7:0] O_F10   = 8'h16;
  localparam logic [7:0] O_F11   = 8'h17;

  water_level_controller dut (
    .clk(clk), .rst(rst), .fill_req(fill_req), .drain_req(drain_req), .hot_sel(hot_sel),
    .abort(abort), .doorclosed(doorclosed), .level_full(level_full), .level_empty(level_empty),
    .valve_in_cold(valve_in_cold), .valve_in_hot(valve_in_hot), .valve_out(valve_out),
    .busy(busy), .done(done), .fault(fault), .fault_code(fault_code)
  );

  assign outs = {valve_in_cold, valve_in_hot, valve_out, busy, done, fault, fault_code};

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic fill, input logic drain, input logic hot,
                               input logic abrt, input logic door, input logic full,
                               input logic empty);
    fill_req    = fill;
    drain_req   = drain;
    hot_sel     = hot;
    abort       = abrt;
    doorclosed  = door;
    level_full  = full;
    level_empty = empty;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("reset", outs, O_IDLE);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("idle_after_reset", outs, O_IDLE);

    // T1: hot fill, full rises before edge 10, settles 4 cycles, one done pulse.
    applyStimulus(1, 0, 1, 0, 1, 0, 0);
    checkOutput("t1_enter_fill", outs, O_HOT);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 1, 0, 1, 0, 0);
      checkOutput("t1_filling", outs, O_HOT);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0, 1, 1, 0);
      checkOutput("t1_debouncing", outs, O_HOT);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 0, 1, 1, 0);
      checkOutput("t1_settle", outs, O_BUSY);
    end
    applyStimulus(0, 0, 1, 0, 1, 1, 0);
    checkOutput("t1_done", outs, O_DONE);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("t1_idle", outs, O_IDLE);

    // T2: drain with empty stuck low times out after exactly 40 open cycles.
    applyStimulus(0, 1, 0, 0, 1, 0, 0);
    checkOutput("t2_enter_drain", outs, O_DRAIN);
    for (int i = 1; i < 40; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("t2_draining", outs, O_DRAIN);
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("t2_drain_timeout", outs, O_F10);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("t2_fault_held", outs, O_F10);
    end
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    checkOutput("t2_abort_clears", outs, O_IDLE);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("t2_stays_idle", outs, O_IDLE);

    // T3: cold fill, 20 open cycles, 20 door-open cycles, 30 more open cycles -> done.
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("t3_enter_fill", outs, O_COLD);
    for (int i = 1; i < 20; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("t3_fill_a", outs, O_COLD);
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("t3_paused", outs, O_BUSY);
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("t3_resume", outs, O_COLD);
    for (int i = 0; i < 26; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("t3_fill_b", outs, O_COLD);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 1, 0);
      checkOutput("t3_debouncing", outs, O_COLD);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 1, 0);
      checkOutput("t3_settle", outs, O_BUSY);
    end
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    checkOutput("t3_done", outs, O_DONE);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("t3_idle", outs, O_IDLE);

    // T4: simultaneous requests -> drain wins; door opening mid-drain faults with 11.
    applyStimulus(1, 1, 1, 0, 1, 0, 0);
    checkOutput("t4_drain_wins", outs, O_DRAIN);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_door_fault", outs, O_F11);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_fault_held", outs, O_F11);
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    checkOutput("t4_abort", outs, O_IDLE);

    // T5: one-cycle full glitches every third cycle never debounce; fill times out at 60.
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("t5_enter_fill", outs, O_COLD);
    for (int i = 1; i < 60; i++) begin
      applyStimulus(0, 0, 0, 0, 1, (i % 3) == 0, 0);
      checkOutput("t5_glitch_fill", outs, O_COLD);
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("t5_fill_timeout", outs, O_F01);
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    checkOutput("t5_abort", outs, O_IDLE);

    // T6: reset mid-drain, then abort mid-fill with no done pulse afterwards.
    applyStimulus(0, 1, 0, 0, 1, 0, 0);
    checkOutput("t6_enter_drain", outs, O_DRAIN);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("t6_draining", outs, O_DRAIN);
    end
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("t6_reset_mid_drain", outs, O_IDLE);
    rst = 1'b0;
    applyStimulus(1, 0, 1, 0, 1, 0, 0);
    checkOutput("t6_enter_fill", outs, O_HOT);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0, 1, 0, 0);
      checkOutput("t6_filling", outs, O_HOT);
    end
    applyStimulus(0, 0, 1, 1, 1, 0, 0);
    checkOutput("t6_abort_fill", outs, O_IDLE);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("t6_no_done", outs, O_IDLE);
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
